// File: rtl/lm32_dp_ram_be.sv
// rtl/lm32_dp_ram_be.sv - dual-port RAM with byte-lane write enables and self-clearing sweep
//
// Purpose:
//   Simple dual-port (one write, one read) word RAM of 2**addr_width words.
//   After reset, or on a clear_i request, the array is zeroed one word per
//   cycle. While that sweep runs, busy_o is high and port accesses are ignored.
//
// Ports:
//   clk_i     - clock, all state changes on the rising edge
//   rst_n_i   - asynchronous active-low reset
//   clear_i   - request to zero the whole array (ignored while sweeping)
//   we_i      - write enable
//   be_i      - byte-lane write enables, bit n covers wdata_i[8n+7:8n]
//   waddr_i   - write word address
//   wdata_i   - write data
//   re_i      - read enable
//   raddr_i   - read word address
//   rdata_o   - registered read data, held when no read is performed
//   rvalid_o  - one-cycle pulse when rdata_o was updated
//   busy_o    - array clear in progress
//
// Configuration:
//   LM32_DP_RAM_BYPASS_EN - when defined, a same-address read-during-write
//   returns write-first data per byte lane. When undefined, it returns the
//   old word (read-first), and no forwarding logic is built.

module lm32_dp_ram_be #(
  parameter int addr_width = 10,
  parameter int data_width = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      clear_i,
  input  logic                      we_i,
  input  logic [data_width/8-1:0]   be_i,
  input  logic [addr_width-1:0]     waddr_i,
  input  logic [data_width-1:0]     wdata_i,
  input  logic                      re_i,
  input  logic [addr_width-1:0]     raddr_i,
  output logic [data_width-1:0]     rdata_o,
  output logic                      rvalid_o,
  output logic                      busy_o
);

  localparam int depth = 1 << addr_width;
  localparam int lanes = data_width / 8;

  localparam logic [addr_width-1:0] cnt_one = {{(addr_width-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [addr_width-1:0]   cnt_q, cnt_d;

  logic [data_width-1:0]   mem [depth];

  logic                    wr_en;
  logic                    rd_en;
  logic [data_width-1:0]   rd_word;
  logic [data_width-1:0]   rdata_q;
  logic                    rvalid_q;

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        // The counter wraps back to 0 on the last word, leaving it ready
        // for the next sweep.
        cnt_d = cnt_q + cnt_one;
        if (cnt_q == '1) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (clear_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o = (state_q == ST_CLEAR);
  assign wr_en  = (state_q == ST_READY) && we_i;
  assign rd_en  = (state_q == ST_READY) && re_i;

  // ---------------------------------------------------------------------------
  // Storage. The sweep owns the write port while busy. A write that coincides
  // with clear_i still lands here; the following sweep then zeroes it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (busy_o) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < lanes; i++) begin
        if (be_i[i]) begin
          mem[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_word = mem[raddr_i];
`ifdef LM32_DP_RAM_BYPASS_EN
    // Forward only the lanes being written this cycle; others show old bytes.
    for (int i = 0; i < lanes; i++) begin
      if (wr_en && be_i[i] && (waddr_i == raddr_i)) begin
        rd_word[8*i +: 8] = wdata_i[8*i +: 8];
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_en;
      if (rd_en) begin
        rdata_q <= rd_word;
      end
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: tb/tb_lm32_dp_ram_be.sv
// tb/tb_lm32_dp_ram_be.sv - directed self-checking bench for lm32_dp_ram_be (addr_width=4)

module tb_lm32_dp_ram_be;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = 4'h0;
  logic [3:0]  waddr_i = 4'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        re_i = 1'b0;
  logic [3:0]  raddr_i = 4'h0;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        busy_o;

  int checks = 0;
  int failures = 0;
  int n;

  lm32_dp_ram_be #(.addr_width(4), .data_width(32)) dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clear_i  (clear_i),
    .we_i     (we_i),
    .be_i     (be_i),
    .waddr_i  (waddr_i),
    .wdata_i  (wdata_i),
    .re_i     (re_i),
    .raddr_i  (raddr_i),
    .rdata_o  (rdata_o),
    .rvalid_o (rvalid_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy_o && cnt < 100) begin
      @(posedge clk_i);
      cnt++;
      #1;
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk_i);
    we_i = 1'b1; waddr_i = a; wdata_i = d; be_i = be;
    @(posedge clk_i);
    #1;
    we_i = 1'b0; be_i = 4'h0;
  endtask

  task automatic do_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
    @(negedge clk_i);
    re_i = 1'b1; raddr_i = a;
    @(posedge clk_i);
    #1;
    re_i = 1'b0;
    check({tag, "_rvalid"}, {31'd0, rvalid_o}, 32'd1);
    check({tag, "_rdata"}, rdata_o, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd1);

    // Initial sweep after release: exactly 16 busy cycles, all words zero
    rst_n_i = 1'b1;
    count_busy(n);
    check("init_sweep_len", n, 32'd16);
    for (int a = 0; a < 16; a++) begin
      do_read("init_zero", a[3:0], 32'h0);
    end

    // Byte-lane merge
    do_write(4'd5, 32'hAABBCCDD, 4'b1111);
    do_write(4'd5, 32'h11223344, 4'b0101);
    do_read("lane_merge", 4'd5, 32'hAA22CC44);
    @(posedge clk_i);
    #1;
    check("hold_rvalid", {31'd0, rvalid_o}, 32'd0);
    check("hold_rdata", rdata_o, 32'hAA22CC44);

    // be_i = 0 writes nothing
    do_write(4'd5, 32'h00000000, 4'b0000);
    do_read("be_zero", 4'd5, 32'hAA22CC44);

    // Simultaneous read/write to different addresses
    @(negedge clk_i);
    we_i = 1'b1; waddr_i = 4'd6; wdata_i = 32'h00000055; be_i = 4'hF;
    re_i = 1'b1; raddr_i = 4'd5;
    @(posedge clk_i);
    #1;
    we_i = 1'b0; re_i = 1'b0; be_i = 4'h0;
    check("diff_addr_rdata", rdata_o, 32'hAA22CC44);
    do_read("diff_addr_wr", 4'd6, 32'h00000055);

    // Same-address read-during-write
    do_write(4'd3, 32'h12345678, 4'hF);
    @(negedge clk_i);
    we_i = 1'b1; waddr_i = 4'd3; wdata_i = 32'hFFFFFFFF; be_i = 4'b0011;
    re_i = 1'b1; raddr_i = 4'd3;
    @(posedge clk_i);
    #1;
    we_i = 1'b0; re_i = 1'b0; be_i = 4'h0;
    check("rdw_rvalid", {31'd0, rvalid_o}, 32'd1);
`ifdef LM32_DP_RAM_BYPASS_EN
    check("rdw_rdata", rdata_o, 32'h1234FFFF);
`else
    check("rdw_rdata", rdata_o, 32'h12345678);
`endif
    do_read("rdw_after", 4'd3, 32'h1234FFFF);

    // Fill with DEADBEEF, then clear with a coincident write
    for (int a = 0; a < 16; a++) begin
      do_write(a[3:0], 32'hDEADBEEF, 4'hF);
    end
    do_read("fill", 4'd11, 32'hDEADBEEF);
    @(negedge clk_i);
    clear_i = 1'b1;
    we_i = 1'b1; waddr_i = 4'd2; wdata_i = 32'h00000001; be_i = 4'hF;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0; we_i = 1'b0; be_i = 4'h0;
    check("clear_busy", {31'd0, busy_o}, 32'd1);
    n = 0;
    while (busy_o && n < 100) begin
      if (n == 3) begin
        clear_i = 1'b1;
        we_i = 1'b1; waddr_i = 4'd0; wdata_i = 32'hCAFEF00D; be_i = 4'hF;
        re_i = 1'b1; raddr_i = 4'd1;
      end
      @(posedge clk_i);
      n++;
      #1;
      if (n == 4) begin
        clear_i = 1'b0; we_i = 1'b0; re_i = 1'b0; be_i = 4'h0;
        check("sweep_rvalid", {31'd0, rvalid_o}, 32'd0);
        check("sweep_rdata_hold", rdata_o, 32'hDEADBEEF);
      end
    end
    check("clear_sweep_len", n, 32'd16);
    for (int a = 0; a < 16; a++) begin
      do_read("cleared", a[3:0], 32'h0);
    end

    // Reset mid-sweep at counter 7
    do_write(4'd9, 32'h00000099, 4'hF);
    do_read("pre_rst", 4'd9, 32'h00000099);
    @(negedge clk_i);
    clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
    repeat (7) @(posedge clk_i);
    #1;
    check("mid_sweep_busy", {31'd0, busy_o}, 32'd1);
    check("mid_sweep_rdata", rdata_o, 32'h00000099);
    #1;
    rst_n_i = 1'b0;
    #1;
    check("async_rdata", rdata_o, 32'h0);
    check("async_rvalid", {31'd0, rvalid_o}, 32'd0);
    check("async_busy", {31'd0, busy_o}, 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    count_busy(n);
    check("rst_sweep_len", n, 32'd16);
    do_read("post_rst", 4'd9, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lm32_dp_ram_be.md
LM32_DP_RAM_BE -- requirements
Module: lm32_dp_ram_be

Interface
REQ-001 Parameter addr_width, default 10, word address width; depth = 2^addr_width words.
REQ-002 Parameter data_width, default 32, word width; SHALL be a multiple of 8; lanes = data_width/8.
REQ-003 clk_i  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 clear_i  input  1  request to zero the whole array; single-cycle pulse sufficient.
REQ-006 we_i  input  1  write enable.
REQ-007 be_i  input  lanes  byte-lane write enables; bit n covers wdata_i[8n+7:8n].
REQ-008 waddr_i  input  addr_width  write word address.
REQ-009 wdata_i  input  data_width  write data.
REQ-010 re_i  input  1  read enable.
REQ-011 raddr_i  input  addr_width  read word address.
REQ-012 rdata_o  output  data_width  registered read data.
REQ-013 rvalid_o  output  1  one-cycle pulse, rdata_o updated this cycle.
REQ-014 busy_o  output  1  array clear in progress; port accesses ignored.

Function
REQ-015 Two states: CLEAR, READY. Clear counter is addr_width bits wide.
REQ-016 CLEAR: each cycle writes all-zero to word at counter, then increments counter; busy_o=1.
REQ-017 CLEAR -> READY on the cycle the word at depth-1 is written; busy_o=0 from the next cycle. A full sweep takes exactly depth cycles.
REQ-018 READY -> CLEAR when clear_i=1; counter restarts at 0. clear_i in CLEAR is ignored (no restart).
REQ-019 In CLEAR, we_i and re_i are ignored; rvalid_o=0; rdata_o holds.
REQ-020 READY write: when we_i=1, each lane with be_i[n]=1 is written at waddr_i; lanes with be_i[n]=0 keep their contents. be_i=0 writes nothing.
REQ-021 READY read: when re_i=1, rdata_o = word at raddr_i and rvalid_o=1 on the following cycle (latency 1).
REQ-022 When re_i=0, rdata_o holds its last value and rvalid_o=0.
REQ-023 When clear_i=1 and we_i=1 arrive in the same READY cycle, the write is performed first; the sweep then zeroes that word.
REQ-024 Simultaneous read and write to different addresses are independent.
REQ-025 Read-during-write to the same address: behaviour set by REQ-030/031.
REQ-026 Writes to distinct addresses on back-to-back cycles have no hazard. A read one or more cycles after a write to the same address returns the written data.

Reset
REQ-027 While rst_n_i=0: state=CLEAR, counter=0, rdata_o=0, rvalid_o=0, busy_o=1.
REQ-028 On rst_n_i deassertion the sweep starts at word 0 on the first rising edge.
REQ-029 Reset asserted mid-sweep or mid-access aborts the operation; the sweep restarts from word 0 after release.

Configuration
REQ-030 With LM32_DP_RAM_BYPASS_EN defined, a same-address read-during-write returns write-first data. Enabled lanes return wdata_i bytes; disabled lanes return the old bytes.
REQ-031 Without LM32_DP_RAM_BYPASS_EN, a same-address read-during-write returns read-first data: the contents before the write, all lanes. No forwarding logic is synthesised.

Verification
REQ-032 Reset release, addr_width=4: busy_o=1 for exactly 16 cycles. Then reads of addresses 0..15 each return 0 with rvalid_o pulses.
REQ-033 Write 0xAABBCCDD, be_i=4'b1111, to addr 5. Then write 0x11223344, be_i=4'b0101, to addr 5. Read addr 5 -> 0xAA22CC44 one cycle after re_i.
REQ-034 Addr 3 holds 0x12345678. Same cycle: we_i=1, be_i=4'b0011, wdata_i=0xFFFFFFFF, addr 3, re_i=1, raddr_i=3. With BYPASS_EN -> 0x1234FFFF; without -> 0x12345678.
REQ-035 clear_i pulse after filling all words with 0xDEADBEEF: busy_o=1 for depth cycles. A second clear_i mid-sweep does not extend busy_o; we_i/re_i during the sweep have no effect; all words then read 0.
REQ-036 rst_n_i low for one cycle at sweep counter 7: rdata_o=0, rvalid_o=0, busy_o=1 immediately (asynchronous). A full depth-cycle sweep follows release.
